padio_halfduplex_ctrl: RTL and testbench

PADIO_HALFDUPLEX_CTRL -- requirements
Module: padio_halfduplex_ctrl

---
 rtl/padio_pkg.sv | 25 ++
 rtl/padio_sync2.sv | 35 +++
 rtl/padio_halfduplex_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_padio_halfduplex_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/padio_pkg.sv
// -----------------------------------------------------------------------------
// padio_pkg
// Shared definitions for the half-duplex pad I/O controller:
//   state_t             controller state encoding
//   START_BIT/STOP_BIT  serial frame line levels
//   TX_BITS/RX_BITS     frame lengths (start + 8 data + stop, 8 data)
// -----------------------------------------------------------------------------
package padio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX      = 3'd1,
        ST_TURN    = 3'd2,
        ST_RX_WAIT = 3'd3,
        ST_RX      = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int TX_BITS = 10;
    localparam int RX_BITS = 8;

endpackage

// File: rtl/padio_sync2.sv
// -----------------------------------------------------------------------------
// padio_sync2
// Two-flop synchronizer for the asynchronous pad input. Both flops reset to 1,
// the idle line level, so a reset never fakes a start bit.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   i_d    asynchronous input
//   o_q    synchronized output
// -----------------------------------------------------------------------------
module padio_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state uses non-blocking assignments so r_sync samples
    // the pre-edge value of r_meta, giving a true two-stage chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/padio_halfduplex_ctrl.sv
// -----------------------------------------------------------------------------
// padio_halfduplex_ctrl
// Half-duplex serial controller for a single bidirectional pad. Transmits one
// framed byte, releases the pad for a turnaround, then optionally receives one
// framed byte (with a start-bit timeout).
// Parameters:
//   DIV   clocks per bit period (4..255)
//   TURN  turnaround clocks with the driver released (1..15)
//   TMO   receive start-bit timeout in bit periods (1..255)
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start/wdata/rd_en  transaction request (accepted when busy=0)
//   busy, done         transaction in flight / one-cycle end pulse
//   rdata, rvalid      received byte / one-cycle valid pulse with done
//   timeout            one-cycle pulse with done when no start bit arrived
//   pad_do, pad_oen    pad cell data and output enable (1 = driven)
//   pad_di             pad cell input, asynchronous to clk
// -----------------------------------------------------------------------------
module padio_halfduplex_ctrl
    import padio_pkg::*;
#(
    parameter int DIV  = 8,
    parameter int TURN = 2,
    parameter int TMO  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] wdata,
    input  logic       rd_en,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       timeout,
    output logic       pad_do,
    output logic       pad_oen,
    input  logic       pad_di
);

    // Counter compare points, pre-sized to the 8-bit counters.
    localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);
    localparam logic [7:0] DIV_MID   = 8'(DIV / 2);
    localparam logic [7:0] TURN_LAST = 8'(TURN - 1);
    localparam logic [7:0] TMO_LAST  = 8'(TMO - 1);
    localparam logic [7:0] TX_LAST   = 8'(TX_BITS - 1);
    localparam logic [7:0] RX_LAST   = 8'(RX_BITS);   // period index of data bit 7

    state_t     r_state;
    logic [7:0] r_div_cnt;    // clock within a bit period; also the turnaround count
    logic [7:0] r_bit_cnt;    // TX bit index, RX period index, RX_WAIT period count
    logic [9:0] r_tx_shift;   // frame being sent, LSB on the line
    logic [6:0] r_rx_shift;   // data bits 0..6 collected so far, filled from the top
    logic       r_rd_en;
    logic [7:0] r_rdata;
    logic       r_rx_ok;
    logic       r_tmo;

    logic       w_rx;
    logic       w_div_end;

    padio_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (pad_di),
        .o_q   (w_rx)
    );

    assign w_div_end = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '1;
            r_rx_shift <= '0;
            r_rd_en    <= 1'b0;
            r_rdata    <= '0;
            r_rx_ok    <= 1'b0;
            r_tmo      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_TX;
                        r_tx_shift <= {STOP_BIT, wdata, START_BIT};
                        r_rd_en    <= rd_en;
                        r_div_cnt  <= '0;
                        r_bit_cnt  <= '0;
                        r_rx_ok    <= 1'b0;
                        r_tmo      <= 1'b0;
                    end
                end

                ST_TX: begin
                    if (w_div_end) begin
                        r_div_cnt  <= '0;
                        r_tx_shift <= {STOP_BIT, r_tx_shift[9:1]};
                        if (r_bit_cnt == TX_LAST) begin
                            r_state   <= ST_TURN;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end

                ST_TURN: begin
                    if (r_div_cnt == TURN_LAST) begin
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= r_rd_en ? ST_RX_WAIT : ST_FIN;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end

                ST_RX_WAIT: begin
                    if (w_rx == START_BIT) begin
                        // The detection cycle is clock 0 of the start period,
                        // so the next cycle is already clock 1.
                        r_state   <= ST_RX;
                        r_div_cnt <= 8'd1;
                        r_bit_cnt <= '0;
                    end else if (w_div_end) begin
                        r_div_cnt <= '0;
                        if (r_bit_cnt == TMO_LAST) begin
                            r_state <= ST_FIN;
                            r_tmo   <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end

                ST_RX: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                    // Period 0 is the start bit; periods 1..8 carry data bits 0..7.
                    if (r_bit_cnt != '0 && r_div_cnt == DIV_MID) begin
                        if (r_bit_cnt == RX_LAST) begin
                            r_rdata <= {w_rx, r_rx_shift};
                            r_rx_ok <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_rx_shift <= {w_rx, r_rx_shift[6:1]};
                        end
                    end
                end

                ST_FIN: begin
                    r_state   <= ST_IDLE;
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from state so pad_oen falls in the very cycle
    // the stop bit ends.
    assign busy    = (r_state != ST_IDLE);
    assign pad_oen = (r_state == ST_TX);
    assign pad_do  = pad_oen ? r_tx_shift[0] : STOP_BIT;
    assign done    = (r_state == ST_FIN);
    assign rvalid  = done & r_rx_ok;
    assign timeout = done & r_tmo;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_padio_halfduplex_ctrl.sv
`timescale 1ns/1ps
module tb_padio_halfduplex_ctrl;

    localparam int DIV     = 8;
    localparam int TURN    = 2;
    localparam int TMO     = 64;
    localparam int TX_CLKS = 10 * DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] wdata;
    logic       rd_en;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       rvalid;
    logic       timeout;
    logic       pad_do;
    logic       pad_oen;
    logic       pad_di;

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         done_seen = 0;
    int         accepted  = 0;
    logic [7:0] model_rdata = 8'h00;
    string      cur_tag = "reset";

    typedef struct {
        logic [7:0] wd;
        bit         rd;
        bit         reply;
        logic [7:0] rb;
        int         gap;
        logic [7:0] exp_rdata;
        bit         exp_rv;
        bit         exp_to;
    } vec_t;

    vec_t vecs[7];

    padio_halfduplex_ctrl #(.DIV(DIV), .TURN(TURN), .TMO(TMO)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .wdata   (wdata),
        .rd_en   (rd_en),
        .busy    (busy),
        .done    (done),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .timeout (timeout),
        .pad_do  (pad_do),
        .pad_oen (pad_oen),
        .pad_di  (pad_di)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s cyc=%0d: got 0x%0h expected 0x%0h", cur_tag, name, cyc, act, exp);
        end
    endtask

    // Line level of bit idx of a frame: start 0, data LSB first, stop/idle 1.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic check_idle(input int cyc, input logic [7:0] exp_rd);
        check("busy",    cyc, busy,    0);
        check("pad_oen", cyc, pad_oen, 0);
        check("pad_do",  cyc, pad_do,  1);
        check("done",    cyc, done,    0);
        check("rvalid",  cyc, rvalid,  0);
        check("timeout", cyc, timeout, 0);
        check("rdata",   cyc, rdata,   exp_rd);
    endtask

    // One full transaction; cycle k is observed at the negedge after the k-th
    // edge following acceptance (k=0 is the first TX cycle).
    task automatic run_txn(input logic [7:0] wd, input bit rd, input bit reply,
                           input logic [7:0] rb, input int gap, input bit inject,
                           input logic [7:0] exp_rd, input bit exp_rv, input bit exp_to);
        int s;
        int done_cyc;
        logic exp_do;
        s = TX_CLKS + gap;
        if (!rd)        done_cyc = TX_CLKS + TURN;
        else if (reply) done_cyc = s + 2 + DIV * RX_BITS_C() + DIV / 2 + 1;
        else            done_cyc = TX_CLKS + TURN + TMO * DIV;

        @(negedge clk);
        check("busy_pre", -1, busy, 0);
        start = 1'b1;
        wdata = wd;
        rd_en = rd;
        accepted++;
        for (int k = 0; k <= done_cyc + 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            wdata = ~wd;
            rd_en = ~rd;
            check("pad_oen", k, pad_oen, (k < TX_CLKS) ? 1 : 0);
            if (k < TX_CLKS + TURN || k > done_cyc) begin
                exp_do = (k < TX_CLKS) ? frame_bit(wd, k / DIV) : 1'b1;
                check("pad_do", k, pad_do, exp_do);
            end
            check("busy",    k, busy,    (k <= done_cyc) ? 1 : 0);
            check("done",    k, done,    (k == done_cyc) ? 1 : 0);
            check("rvalid",  k, rvalid,  (k == done_cyc && exp_rv) ? 1 : 0);
            check("timeout", k, timeout, (k == done_cyc && exp_to) ? 1 : 0);
            check("rdata",   k, rdata,   (k >= done_cyc) ? exp_rd : model_rdata);
            if (inject && (k == 4 * DIV + 1 || k == done_cyc)) start = 1'b1;
            pad_di = (rd && reply && k >= s) ? frame_bit(rb, (k - s) / DIV) : 1'b1;
        end
        pad_di = 1'b1;
        model_rdata = exp_rd;
    endtask

    function automatic int RX_BITS_C();
        return 8;
    endfunction

    initial begin
        bit         rd;
        bit         rp;
        logic [7:0] wd;
        logic [7:0] rb;
        logic [7:0] erd;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'h00, 0,  8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'h5A, 1'b1, 1'b1, 8'h3C, 3,  8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 8'h00, 0,  8'h3C, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h81, 0,  8'h81, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b0, 1'b0, 8'h00, 0,  8'h81, 1'b0, 1'b0};
        vecs[5] = '{8'hC3, 1'b1, 1'b1, 8'h00, 17, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h7E, 1'b1, 1'b1, 8'hFF, 30, 8'hFF, 1'b1, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        wdata  = 8'h00;
        rd_en  = 1'b0;
        pad_di = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle(0, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            run_txn(vecs[i].wd, vecs[i].rd, vecs[i].reply, vecs[i].rb, vecs[i].gap, 1'b0,
                    vecs[i].exp_rdata, vecs[i].exp_rv, vecs[i].exp_to);
        end

        // Start pulses mid-TX and in the done cycle must be ignored.
        cur_tag = "inject";
        run_txn(8'h96, 1'b1, 1'b1, 8'h55, 5, 1'b1, 8'h55, 1'b1, 1'b0);

        // Reset during TX bit 4, then a fresh transaction.
        cur_tag = "reset_mid_tx";
        @(negedge clk);
        start = 1'b1;
        wdata = 8'h6B;
        rd_en = 1'b1;
        for (int k = 0; k <= 4 * DIV + 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("pad_oen", k, pad_oen, 1);
            check("pad_do",  k, pad_do,  frame_bit(8'h6B, k / DIV));
            if (k == 4 * DIV + 2) reset = 1'b1;
        end
        @(negedge clk);
        model_rdata = 8'h00;
        check_idle(0, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        check_idle(1, 8'h00);
        cur_tag = "after_reset";
        run_txn(8'h6B, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset wins over start in the same cycle.
        cur_tag = "reset_vs_start";
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        wdata = 8'hAA;
        rd_en = 1'b0;
        @(negedge clk);
        check_idle(0, 8'h00);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle(1, 8'h00);

        // Randomized transactions against the frame-level model.
        for (int i = 0; i < 12; i++) begin
            cur_tag = $sformatf("rand%0d", i);
            wd  = 8'($urandom);
            rb  = 8'($urandom);
            rd  = 1'($urandom_range(0, 1));
            rp  = rd && ($urandom_range(0, 5) != 0);
            erd = (rd && rp) ? rb : model_rdata;
            run_txn(wd, rd, rp, rb, int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)),
                    erd, rd && rp, rd && !rp);
        end

        cur_tag = "end";
        repeat (4) @(negedge clk);
        check("done_count", 0, done_seen, accepted);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
